// File: rtl/ysyx_23060075_lut_cam.sv
// ysyx_23060075_lut_cam
// Writable key->data lookup table with a registered, one-deep response.
// Entries are (key, data, valid). Lookups see the table as it will be after
// this cycle's inv_all/write, and resolve multiple hits to the lowest index.
//
// Handshake: a transfer happens on a channel when valid and ready are both
// high at a rising edge. A producer holds valid and its payload stable until
// accepted. req_ready depends only on the response register and rsp_ready,
// so the only combinational path through the block is rsp_ready -> req_ready.
// rsp_* payload is stable while rsp_valid & !rsp_ready.

module ysyx_23060075_lut_cam #(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 8,
   parameter int DATA_LEN = 32,
   localparam int IDX_LEN = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [IDX_LEN-1:0]  wr_idx,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                inv_all,
   input  logic [DATA_LEN-1:0] dflt,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [KEY_LEN-1:0]  req_key,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_LEN-1:0] rsp_data,
   output logic                rsp_hit,
   output logic [IDX_LEN-1:0]  rsp_idx
);

   // Table storage
   logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q,   key_d;
   logic [NR_KEY-1:0][DATA_LEN-1:0] data_q,  data_d;
   logic [NR_KEY-1:0]               valid_q, valid_d;

   // Response register
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_hit_q,   rsp_hit_d;
   logic [IDX_LEN-1:0]  rsp_idx_q,   rsp_idx_d;
   logic [DATA_LEN-1:0] rsp_data_q,  rsp_data_d;

   // Lookup result against the post-update table
   logic                lk_hit;
   logic [IDX_LEN-1:0]  lk_idx;
   logic [DATA_LEN-1:0] lk_data;

   logic fire;

   assign req_ready = !rsp_valid_q || rsp_ready;
   assign fire      = req_valid && req_ready;

   // Next table state: invalidate first, then the write (out-of-range index matches no entry)
   always_comb begin
      key_d   = key_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (inv_all) begin
         valid_d = '0;
      end
      for (int i = 0; i < NR_KEY; i++) begin
         if (wr_en && (wr_idx == IDX_LEN'(i))) begin
            key_d[i]   = wr_key;
            data_d[i]  = wr_data;
            valid_d[i] = 1'b1;
         end
      end
   end

   // Priority match on the bypassed table: first matching entry wins
   always_comb begin
      lk_hit  = 1'b0;
      lk_idx  = '0;
      lk_data = dflt;
      for (int i = 0; i < NR_KEY; i++) begin
         if (!lk_hit && valid_d[i] && (key_d[i] == req_key)) begin
            lk_hit  = 1'b1;
            lk_idx  = IDX_LEN'(i);
            lk_data = data_d[i];
         end
      end
   end

   // Response next state: load on fire, drain on consume, otherwise hold
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_idx_d   = rsp_idx_q;
      rsp_data_d  = rsp_data_q;
      if (fire) begin
         rsp_valid_d = 1'b1;
         rsp_hit_d   = lk_hit;
         rsp_idx_d   = lk_idx;
         rsp_data_d  = lk_data;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Table registers, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q   <= '0;
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         key_q   <= key_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Response registers; reset discards any pending response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_idx_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_idx_q   <= rsp_idx_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_idx   = rsp_idx_q;
   assign rsp_data  = rsp_data_q;

endmodule
